// File: rtl/commit_unit.sv
// -----------------------------------------------------------------------------
// commit_unit
// Retire stage behind the ROB. Committed entries from up to IN_WIDTH lanes are
// queued in a small circular FIFO. Entries are retired in order, at most one
// per cycle, and each retirement performs its architectural side effect:
// register write, store (request/acknowledge), taken jump (flush + redirect)
// or halt.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/uid/val/loc : commit lanes, lane 0 oldest, valid lanes contiguous
//                       loc = {jump, store, addr/reg[15:0]}
//   in_ready          : at least IN_WIDTH free slots (and not flushing)
//   rf_we/waddr/wdata : register write port (single-cycle pulse)
//   mem_req/addr/wdata, mem_ack : store handshake, request held until ack
//   retire_valid/uid  : one pulse per retired entry
//   flush_all, redirect_pc : one-cycle flush with the jump target
//   halted, overflow_err   : sticky status flags
// -----------------------------------------------------------------------------
module commit_unit #(
    parameter int ROB_BITS  = 3,
    parameter int IN_WIDTH  = 2,
    parameter int BUF_DEPTH = 8,
    parameter int REG_BITS  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN_WIDTH-1:0]      in_valid,
    input  logic [IN_WIDTH*ROB_BITS-1:0] in_uid,
    input  logic [IN_WIDTH*16-1:0]   in_val,
    input  logic [IN_WIDTH*18-1:0]   in_loc,
    output logic                     in_ready,
    output logic                     rf_we,
    output logic [REG_BITS-1:0]      rf_waddr,
    output logic [15:0]              rf_wdata,
    output logic                     mem_req,
    output logic [15:0]              mem_addr,
    output logic [15:0]              mem_wdata,
    input  logic                     mem_ack,
    output logic                     retire_valid,
    output logic [ROB_BITS-1:0]      retire_uid,
    output logic                     flush_all,
    output logic [15:0]              redirect_pc,
    output logic                     halted,
    output logic                     overflow_err
);
    localparam int PTR_BITS = $clog2(BUF_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    typedef enum logic [1:0] {S_RUN, S_STORE_WAIT, S_FLUSH, S_HALT} state_t;

    state_t r_state, w_state_next;

    logic [PTR_BITS-1:0] r_head, r_tail;
    logic [CNT_BITS-1:0] r_count;

    logic [ROB_BITS-1:0] r_uid_mem [BUF_DEPTH];
    logic [15:0]         r_val_mem [BUF_DEPTH];
    logic [17:0]         r_loc_mem [BUF_DEPTH];

    logic [ROB_BITS-1:0] w_head_uid;
    logic [15:0]         w_head_val;
    logic [17:0]         w_head_loc;
    logic                w_empty;

    // Decoded actions for this edge
    logic w_pop, w_clear, w_push_en;
    logic w_reg_wr, w_store_issue, w_store_done, w_jump, w_halt;

    logic [CNT_BITS-1:0] w_n_valid, w_free, w_space, w_n_push;
    logic                w_overflow;

    logic [PTR_BITS-1:0] w_wr_idx [IN_WIDTH];
    logic [IN_WIDTH-1:0] w_lane_we;

    assign w_head_uid = r_uid_mem[r_head];
    assign w_head_val = r_val_mem[r_head];
    assign w_head_loc = r_loc_mem[r_head];
    assign w_empty    = (r_count == '0);

    // ---------------- next-state / action decode ----------------
    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        w_clear       = 1'b0;
        w_push_en     = 1'b1;
        w_reg_wr      = 1'b0;
        w_store_issue = 1'b0;
        w_store_done  = 1'b0;
        w_jump        = 1'b0;
        w_halt        = 1'b0;
        case (r_state)
            S_RUN: begin
                if (!w_empty) begin
                    case (w_head_loc[17:16])
                        2'b00: begin
                            w_reg_wr = 1'b1;
                            w_pop    = 1'b1;
                        end
                        2'b01: begin
                            // The store stays at head until acknowledged.
                            w_store_issue = 1'b1;
                            w_state_next  = S_STORE_WAIT;
                        end
                        2'b10: begin
                            // Everything younger than the jump is wrong-path,
                            // including lanes arriving this very cycle.
                            w_jump       = 1'b1;
                            w_clear      = 1'b1;
                            w_push_en    = 1'b0;
                            w_state_next = S_FLUSH;
                        end
                        default: begin
                            w_halt       = 1'b1;
                            w_pop        = 1'b1;
                            w_state_next = S_HALT;
                        end
                    endcase
                end
            end
            S_STORE_WAIT: begin
                if (mem_ack) begin
                    w_store_done = 1'b1;
                    w_pop        = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_FLUSH: begin
                w_push_en    = 1'b0;
                w_state_next = S_RUN;
            end
            default: ;  // S_HALT: terminal until reset
        endcase
    end

    // ---------------- push accounting ----------------
    always_comb begin
        w_n_valid = '0;
        for (int k = 0; k < IN_WIDTH; k++) begin
            w_n_valid = w_n_valid + CNT_BITS'(in_valid[k]);
        end
    end

    assign w_free   = CNT_BITS'(BUF_DEPTH) - r_count;
    // A same-edge pop frees a slot, so a push at full is legal when retiring.
    assign w_space  = w_free + CNT_BITS'(w_pop);
    assign in_ready = (r_state != S_FLUSH) && (w_free >= CNT_BITS'(IN_WIDTH));

    always_comb begin
        w_n_push   = '0;
        w_overflow = 1'b0;
        if (w_push_en) begin
            if (w_n_valid > w_space) begin
                w_n_push   = w_space;
                w_overflow = 1'b1;
            end else begin
                w_n_push = w_n_valid;
            end
        end
    end

    for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_lane
        assign w_wr_idx[gi]  = r_tail + PTR_BITS'(gi);
        assign w_lane_we[gi] = (CNT_BITS'(gi) < w_n_push);
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        for (int k = 0; k < IN_WIDTH; k++) begin
            if (w_lane_we[k]) begin
                r_uid_mem[w_wr_idx[k]] <= in_uid[k*ROB_BITS +: ROB_BITS];
                r_val_mem[w_wr_idx[k]] <= in_val[k*16 +: 16];
                r_loc_mem[w_wr_idx[k]] <= in_loc[k*18 +: 18];
            end
        end
    end

    // ---------------- state, pointers and outputs ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_RUN;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            retire_valid <= 1'b0;
            retire_uid   <= '0;
            flush_all    <= 1'b0;
            redirect_pc  <= '0;
            halted       <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            rf_we        <= w_reg_wr;
            flush_all    <= w_jump;
            retire_valid <= w_reg_wr | w_store_done | w_jump | w_halt;

            if (w_reg_wr | w_store_done | w_jump | w_halt) begin
                retire_uid <= w_head_uid;
            end
            if (w_reg_wr) begin
                rf_waddr <= w_head_loc[REG_BITS-1:0];
                rf_wdata <= w_head_val;
            end
            if (w_store_issue) begin
                mem_req   <= 1'b1;
                mem_addr  <= w_head_loc[15:0];
                mem_wdata <= w_head_val;
            end else if (w_store_done) begin
                mem_req <= 1'b0;
            end
            if (w_jump) begin
                redirect_pc <= w_head_val;
            end
            if (w_halt) begin
                halted <= 1'b1;
            end
            if (w_overflow) begin
                overflow_err <= 1'b1;
            end

            if (w_clear) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + PTR_BITS'(w_pop);
                r_tail  <= r_tail + PTR_BITS'(w_n_push);
                r_count <= r_count + w_n_push - CNT_BITS'(w_pop);
            end
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
module tb_commit_unit;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [2:0]  uid;
        logic [15:0] val;
        logic [17:0] loc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  in_valid = '0;
    logic [5:0]  in_uid = '0;
    logic [31:0] in_val = '0;
    logic [35:0] in_loc = '0;
    logic        in_ready;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        retire_valid;
    logic [2:0]  retire_uid;
    logic        flush_all;
    logic [15:0] redirect_pc;
    logic        halted;
    logic        overflow_err;

    commit_unit dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_uid(in_uid), .in_val(in_val), .in_loc(in_loc),
        .in_ready(in_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .retire_valid(retire_valid), .retire_uid(retire_uid),
        .flush_all(flush_all), .redirect_pc(redirect_pc),
        .halted(halted), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int mreq_seen = 0;
    string phase = "init";

    // ---------------- reference model ----------------
    ent_t        q[$];
    logic        waiting_store, flushing, is_halted;
    logic        exp_rf_we, exp_ret, exp_flush, exp_mreq, exp_halted, exp_ovf;
    logic [2:0]  exp_waddr, exp_uid;
    logic [15:0] exp_wdata, exp_pc, exp_maddr, exp_mdata;
    logic [2:0]  next_uid;

    task automatic model_reset();
        q.delete();
        waiting_store = 0; flushing = 0; is_halted = 0;
        exp_rf_we = 0; exp_ret = 0; exp_flush = 0; exp_mreq = 0;
        exp_halted = 0; exp_ovf = 0;
        exp_waddr = 0; exp_uid = 0; exp_wdata = 0; exp_pc = 0;
        exp_maddr = 0; exp_mdata = 0;
        next_uid = 0;
    endtask

    function automatic logic model_ready();
        return !flushing && ((DEPTH - q.size()) >= 2);
    endfunction

    // Effect of one clock edge given the inputs presented in the cycle before it.
    task automatic model_edge(input int nv, input ent_t e0, input ent_t e1, input logic ack);
        ent_t h;
        logic can_push;
        exp_rf_we = 0; exp_ret = 0; exp_flush = 0;
        can_push = 1;
        if (flushing) begin
            flushing = 0;
            can_push = 0;
        end else if (is_halted) begin
            // nothing retires
        end else if (waiting_store) begin
            if (ack) begin
                exp_ret = 1; exp_uid = q[0].uid;
                void'(q.pop_front());
                waiting_store = 0; exp_mreq = 0;
            end
        end else if (q.size() != 0) begin
            h = q[0];
            case (h.loc[17:16])
                2'b00: begin
                    exp_rf_we = 1; exp_waddr = h.loc[2:0]; exp_wdata = h.val;
                    exp_ret = 1; exp_uid = h.uid;
                    void'(q.pop_front());
                end
                2'b01: begin
                    exp_mreq = 1; exp_maddr = h.loc[15:0]; exp_mdata = h.val;
                    waiting_store = 1;
                end
                2'b10: begin
                    exp_flush = 1; exp_pc = h.val;
                    exp_ret = 1; exp_uid = h.uid;
                    q.delete();
                    can_push = 0;
                    flushing = 1;
                end
                default: begin
                    exp_halted = 1; is_halted = 1;
                    exp_ret = 1; exp_uid = h.uid;
                    void'(q.pop_front());
                end
            endcase
        end
        if (can_push) begin
            for (int i = 0; i < nv; i++) begin
                if (q.size() < DEPTH) q.push_back(i == 0 ? e0 : e1);
                else exp_ovf = 1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("rf", 64'({rf_we, rf_we ? rf_waddr : 3'd0, rf_we ? rf_wdata : 16'd0}),
                  64'({exp_rf_we, exp_rf_we ? exp_waddr : 3'd0, exp_rf_we ? exp_wdata : 16'd0}));
        chk("retire", 64'({retire_valid, retire_valid ? retire_uid : 3'd0}),
                      64'({exp_ret, exp_ret ? exp_uid : 3'd0}));
        chk("flush", 64'({flush_all, flush_all ? redirect_pc : 16'd0}),
                     64'({exp_flush, exp_flush ? exp_pc : 16'd0}));
        chk("mem", 64'({mem_req, mem_req ? {mem_addr, mem_wdata} : 32'd0}),
                   64'({exp_mreq, exp_mreq ? {exp_maddr, exp_mdata} : 32'd0}));
        chk("flags", 64'({halted, overflow_err}), 64'({exp_halted, exp_ovf}));
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic ent_t mk(input logic [1:0] kind, input logic [15:0] a, input logic [15:0] v);
        ent_t e;
        e.uid = next_uid;
        next_uid = next_uid + 3'd1;
        e.loc = {kind, a};
        e.val = v;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        int r;
        logic [1:0] kind;
        r = $urandom_range(0, 99);
        kind = (r < 65) ? 2'b00 : (r < 85) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
        return mk(kind, 16'($urandom), 16'($urandom));
    endfunction

    task automatic step(input int nv, input ent_t e0, input ent_t e1, input logic ack);
        chk("in_ready", 64'(in_ready), 64'(model_ready()));
        in_valid = (nv == 0) ? 2'b00 : (nv == 1) ? 2'b01 : 2'b11;
        in_uid   = {e1.uid, e0.uid};
        in_val   = {e1.val, e0.val};
        in_loc   = {e1.loc, e0.loc};
        mem_ack  = ack;
        model_edge(nv, e0, e1, ack);
        @(posedge clk); #1;
        in_valid = '0;
        mem_ack  = 1'b0;
        if (mem_req) mreq_seen++;
        if (retire_valid) $display("[TB] %s retire uid=%0d", phase, retire_uid);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic ack);
        ent_t z;
        z = '0;
        for (int i = 0; i < n; i++) step(0, z, z, ack);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = '0; mem_ack = 1'b0;
        @(posedge clk); #1;
        model_reset();
        reset = 1'b0;
        check_outputs();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        ent_t z, a, b;
        int pushed, nv;
        z = '0;

        phase = "reset";
        do_reset();

        phase = "regpair";
        a = mk(2'b00, 16'd3, 16'h1234);
        b = mk(2'b00, 16'd5, 16'h00FF);
        step(2, a, b, 0);
        idle(3, 0);

        phase = "store";
        mreq_seen = 0;
        step(1, mk(2'b01, 16'h0040, 16'hBEEF), z, 0);
        idle(4, 0);
        idle(1, 1);
        idle(2, 0);
        chk("mreq_cycles", 64'(mreq_seen), 64'd4);

        phase = "jump";
        a = mk(2'b10, 16'h0000, 16'h0100);
        b = mk(2'b00, 16'd1, 16'hAAAA);
        step(2, a, b, 0);
        step(2, mk(2'b00, 16'd6, 16'h6666), mk(2'b00, 16'd7, 16'h7777), 0);
        step(2, mk(2'b00, 16'd4, 16'h4444), mk(2'b00, 16'd5, 16'h5555), 0);
        idle(3, 0);

        phase = "halt";
        step(2, mk(2'b11, 16'h0000, 16'h0000), mk(2'b00, 16'd2, 16'h2222), 0);
        idle(4, 0);
        chk("halted_sticky", 64'(halted), 64'd1);
        do_reset();

        phase = "fill";
        step(2, mk(2'b01, 16'h0080, 16'h5555), mk(2'b00, 16'd1, 16'h0101), 0);
        for (int i = 0; i < 3; i++)
            step(2, mk(2'b00, 16'($urandom), 16'($urandom)), mk(2'b00, 16'($urandom), 16'($urandom)), 0);
        step(2, mk(2'b00, 16'd2, 16'hDEAD), mk(2'b00, 16'd3, 16'hDEAD), 0);
        chk("overflow_set", 64'(overflow_err), 64'd1);
        step(1, mk(2'b00, 16'd4, 16'h0404), z, 1);
        idle(10, 0);

        phase = "wrap";
        pushed = 0;
        for (int i = 0; i < 40 && pushed < 12; i++) begin
            if (model_ready()) begin
                step(2, mk(2'b00, 16'($urandom), 16'($urandom)), mk(2'b00, 16'($urandom), 16'($urandom)), 0);
                pushed += 2;
            end else begin
                idle(1, 0);
            end
        end
        idle(12, 0);

        phase = "rst_store";
        step(1, mk(2'b01, 16'h0123, 16'h4567), z, 0);
        idle(2, 0);
        do_reset();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        step(1, mk(2'b00, 16'd6, 16'h0606), z, 0);
        idle(2, 0);

        phase = "random";
        for (int i = 0; i < 500; i++) begin
            if ((is_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                nv = $urandom_range(0, 2);
                if (!model_ready() && $urandom_range(0, 3) != 0) nv = 0;
                a = rand_ent();
                b = rand_ent();
                step(nv, a, b, 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
